// File: rtl/hc_pkg.sv
// rtl/hc_pkg.sv - shared constants and request FSM encoding for the HC stream XOR block
package hc_pkg;

    localparam int HC_WORD_W        = 32;
    localparam int HC_DEFAULT_DEPTH = 4;

    // One keystream request may be outstanding at a time.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hc_req_state_e;

endpackage

// File: rtl/hc_stream_xor_if.sv
// rtl/hc_stream_xor_if.sv - data-in / data-out valid-ready streams of the HC XOR stage
interface hc_stream_xor_if;
    import hc_pkg::*;

    logic [HC_WORD_W-1:0] din;
    logic                 din_valid;
    logic                 din_ready;
    logic [HC_WORD_W-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;

    // Block side: consumes din, produces dout.
    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );

    // Environment side: produces din, consumes dout.
    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );
endinterface

// File: rtl/hc_ks_fifo.sv
// rtl/hc_ks_fifo.sv - DEPTH x 32 keystream FIFO, occupancy-tracked, with synchronous flush
module hc_ks_fifo
    import hc_pkg::*;
#(
    parameter int DEPTH = HC_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [HC_WORD_W-1:0]     push_data_i,
    input  logic                     pop_i,
    output logic [HC_WORD_W-1:0]     head_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [HC_WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       level_q, level_d;

    // Next pointers and occupancy; flush wins over any push/pop that cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; unreset, only read where the level marks it valid.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/hc_stream_xor.sv
// rtl/hc_stream_xor.sv - buffers HC keystream words and XORs them onto a 32-bit data stream
module hc_stream_xor
    import hc_pkg::*;
#(
    parameter int DEPTH = HC_DEFAULT_DEPTH,
    parameter int CTR_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    core_ready,
    input  logic [HC_WORD_W-1:0]    ks_word,
    input  logic                    ks_valid,
    output logic                    ks_next,
    input  logic                    flush,
    hc_stream_xor_if.slave          s,
    output logic [$clog2(DEPTH):0]  ks_level,
    output logic [CTR_W-1:0]        word_cnt
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    hc_req_state_e        state_q, state_d;
    logic                 drop_q, drop_d;
    logic                 ks_next_q, ks_next_d;
    logic [HC_WORD_W-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [CTR_W-1:0]     cnt_q, cnt_d;

    logic                 ks_push;
    logic                 din_ready;
    logic                 din_hs;
    logic                 dout_hs;
    logic [HC_WORD_W-1:0] ks_head;
    logic [LVL_W-1:0]     level;

    hc_ks_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (reset_n),
        .flush_i     (flush),
        .push_i      (ks_push),
        .push_data_i (ks_word),
        .pop_i       (din_hs),
        .head_o      (ks_head),
        .level_o     (level)
    );

    // Request FSM: one outstanding request; its FIFO slot is reserved by the level check.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        ks_next_d = 1'b0;
        ks_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_ready && !flush && (level < DEPTH_L)) begin
                    ks_next_d = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (ks_valid) begin
                    ks_push = !drop_q && !flush;
                    drop_d  = 1'b0;
                    state_d = IDLE;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request FSM registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            ks_next_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            ks_next_q <= ks_next_d;
        end
    end

    assign din_ready = (level != '0) && (!dout_valid_q || s.dout_ready) && !flush;
    assign din_hs    = s.din_valid && din_ready;
    assign dout_hs   = dout_valid_q && s.dout_ready;

    // Output stage: XOR on accept, drop valid when drained; dout keeps its last value.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        cnt_d        = cnt_q;
        if (flush) begin
            dout_valid_d = 1'b0;
        end else if (din_hs) begin
            dout_d       = s.din ^ ks_head;
            dout_valid_d = 1'b1;
        end else if (dout_hs) begin
            dout_valid_d = 1'b0;
        end
        if (dout_hs) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output stage and transfer counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ks_next      = ks_next_q;
    assign s.din_ready  = din_ready;
    assign s.dout       = dout_q;
    assign s.dout_valid = dout_valid_q;
    assign ks_level     = level;
    assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_hc_stream_xor.sv
// tb/tb_hc_stream_xor.sv - scoreboard bench for hc_stream_xor with a 3-cycle model HC core
module tb_hc_stream_xor;

    logic        clk;
    logic        reset_n;
    logic        core_ready;
    logic [31:0] ks_word;
    logic        ks_valid;
    logic        ks_next;
    logic        flush;
    logic [2:0]  ks_level;
    logic [7:0]  word_cnt;

    hc_stream_xor_if sif ();

    hc_stream_xor #(.DEPTH(4), .CTR_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .core_ready (core_ready),
        .ks_word    (ks_word),
        .ks_valid   (ks_valid),
        .ks_next    (ks_next),
        .flush      (flush),
        .s          (sif),
        .ks_level   (ks_level),
        .word_cnt   (word_cnt)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;
    int pend     = 0;
    int next_pulses = 0;
    int deliver_cyc = 0;
    int accepted = 0;
    int xfers    = 0;
    bit discard_next = 0;

    logic [31:0] ks_src  [$];
    logic [31:0] exp_ks  [$];
    logic [31:0] data_sb [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Model HC core: ks_valid three cycles after each ks_next; idles while in reset.
    always @(posedge clk) begin
        #1;
        ks_valid = 1'b0;
        if (!reset_n) begin
            pend = 0;
        end else begin
            if (pend != 0) begin
                pend--;
                if (pend == 0) begin
                    ks_valid = 1'b1;
                    ks_word  = (ks_src.size() != 0) ? ks_src.pop_front() : $urandom;
                    deliver_cyc = cyc;
                    if (discard_next) discard_next = 0;
                    else exp_ks.push_back(ks_word);
                end
            end
            if (ks_next) begin
                next_pulses++;
                pend = 3;
            end
        end
    end

    // Scoreboard: predict on din acceptance, compare on dout transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sif.dout_valid && sif.dout_ready) begin
                chk_cnt++;
                if (data_sb.size() == 0) begin
                    $display("FAIL sb_dout: unexpected dout %h, no prediction queued", sif.dout);
                end else begin
                    logic [31:0] e;
                    e = data_sb.pop_front();
                    if (sif.dout !== e) $display("FAIL sb_dout: got %h want %h", sif.dout, e);
                    else pass_cnt++;
                end
                xfers++;
            end
            if (sif.din_valid && sif.din_ready) begin
                if (exp_ks.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb_ks: din accepted with no keystream word expected");
                end else begin
                    data_sb.push_back(sif.din ^ exp_ks.pop_front());
                end
                accepted++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; core_ready = 1'b0; flush = 1'b0;
        ks_valid = 1'b0; ks_word = '0;
        sif.din = '0; sif.din_valid = 1'b0; sif.dout_ready = 1'b0;
        repeat (3) tick();
        chk_cnt++; if (ks_next !== 1'b0) $display("FAIL rst_ks_next: got %b want 0", ks_next); else pass_cnt++;
        chk_cnt++; if (sif.din_ready !== 1'b0) $display("FAIL rst_din_ready: got %b want 0", sif.din_ready); else pass_cnt++;
        chk_cnt++; if (sif.dout !== 32'h0) $display("FAIL rst_dout: got %h want 0", sif.dout); else pass_cnt++;
        chk_cnt++; if (sif.dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %b want 0", sif.dout_valid); else pass_cnt++;
        chk_cnt++; if (ks_level !== 3'd0) $display("FAIL rst_ks_level: got %0d want 0", ks_level); else pass_cnt++;
        chk_cnt++; if (word_cnt !== 8'd0) $display("FAIL rst_word_cnt: got %0d want 0", word_cnt); else pass_cnt++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        ks_src.push_back(32'hA5A5A5A5);
        ks_src.push_back(32'h0F0F0F0F);
        next_pulses = 0;
        core_ready = 1'b1;
        repeat (40) tick();
        chk_cnt++; if (next_pulses != 4) $display("FAIL fill_pulses: got %0d want 4", next_pulses); else pass_cnt++;
        chk_cnt++; if (ks_level !== 3'd4) $display("FAIL fill_level: got %0d want 4", ks_level); else pass_cnt++;
    endtask

    task automatic test_xor();
        sif.dout_ready = 1'b1;
        sif.din = 32'hFFFFFFFF; sif.din_valid = 1'b1;
        tick();
        chk_cnt++; if (sif.dout_valid !== 1'b1 || sif.dout !== 32'h5A5A5A5A)
            $display("FAIL xor_w0: got v=%b %h want v=1 5a5a5a5a", sif.dout_valid, sif.dout); else pass_cnt++;
        sif.din = 32'h12345678;
        tick();
        chk_cnt++; if (sif.dout_valid !== 1'b1 || sif.dout !== 32'h1D3B5977)
            $display("FAIL xor_w1: got v=%b %h want v=1 1d3b5977", sif.dout_valid, sif.dout); else pass_cnt++;
        sif.din_valid = 1'b0;
        tick();
        chk_cnt++; if (word_cnt !== 8'd2) $display("FAIL xor_cnt: got %0d want 2", word_cnt); else pass_cnt++;
        chk_cnt++; if (sif.dout_valid !== 1'b0) $display("FAIL xor_drain: got %b want 0", sif.dout_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int n;
        n = 0;
        while (ks_level < 3'd2 && n < 50) begin tick(); n++; end
        sif.dout_ready = 1'b0;
        sif.din = 32'hCAFEF00D; sif.din_valid = 1'b1;
        tick();
        sif.din = 32'h600DD00D;
        for (int i = 0; i < 10; i++) begin
            chk_cnt++;
            if (sif.din_ready !== 1'b0 || sif.dout_valid !== 1'b1 || data_sb.size() == 0 || sif.dout !== data_sb[0])
                $display("FAIL bp_hold%0d: rdy=%b v=%b dout=%h", i, sif.din_ready, sif.dout_valid, sif.dout);
            else pass_cnt++;
            tick();
        end
        sif.dout_ready = 1'b1;
        #1;
        chk_cnt++; if (sif.din_ready !== 1'b1) $display("FAIL bp_release: din_ready got %b want 1", sif.din_ready); else pass_cnt++;
        tick();
        sif.din_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_empty();
        bit seen;
        int n;
        core_ready = 1'b0;
        repeat (10) tick();
        sif.din_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin sif.din = $urandom; tick(); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin if (sif.din_ready !== 1'b0) seen = 1; tick(); end
        chk_cnt++; if (seen) $display("FAIL empty_ready: din_ready got 1 want 0"); else pass_cnt++;
        sif.din = 32'h0BADF00D;
        core_ready = 1'b1;
        n = 0;
        while (sif.dout_valid !== 1'b1 && n < 30) begin tick(); n++; end
        chk_cnt++; if (sif.dout_valid !== 1'b1 || (cyc - deliver_cyc) != 2)
            $display("FAIL empty_latency: got %0d cycles (v=%b) want 2", cyc - deliver_cyc, sif.dout_valid);
        else pass_cnt++;
        sif.din_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_flush();
        int n;
        n = 0;
        while (ks_level != 3'd4 && n < 60) begin tick(); n++; end
        repeat (8) tick();
        ks_src.push_back(32'hDEADBEEF);
        ks_src.push_back(32'h11111111);
        sif.din_valid = 1'b1;
        tick(); tick();
        sif.din_valid = 1'b0;
        n = 0;
        while (pend == 0 && n < 10) begin tick(); n++; end
        chk_cnt++; if (pend == 0 || ks_level !== 3'd2)
            $display("FAIL flush_setup: pend=%0d level=%0d want WAIT and 2", pend, ks_level); else pass_cnt++;
        tick();
        flush = 1'b1; discard_next = 1; exp_ks.delete(); data_sb.delete();
        tick();
        flush = 1'b0;
        chk_cnt++; if (ks_level !== 3'd0) $display("FAIL flush_level: got %0d want 0", ks_level); else pass_cnt++;
        chk_cnt++; if (sif.dout_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", sif.dout_valid); else pass_cnt++;
        n = 0;
        while (ks_level == 3'd0 && n < 30) begin tick(); n++; end
        sif.din = 32'h0; sif.din_valid = 1'b1;
        tick();
        sif.din_valid = 1'b0;
        chk_cnt++; if (sif.dout_valid !== 1'b1 || sif.dout !== 32'h11111111)
            $display("FAIL flush_next: got v=%b %h want v=1 11111111", sif.dout_valid, sif.dout); else pass_cnt++;
        repeat (2) tick();
    endtask

    task automatic test_wrap();
        int n;
        sif.din_valid = 1'b1;
        n = 0;
        while ((accepted % 256) != 255 && n < 4000) begin sif.din = $urandom; tick(); n++; end
        sif.din_valid = 1'b0;
        repeat (3) tick();
        chk_cnt++; if (word_cnt !== 8'hFF) $display("FAIL wrap_ff: got %h want ff", word_cnt); else pass_cnt++;
        sif.din_valid = 1'b1;
        n = 0;
        while ((accepted % 256) != 0 && n < 100) begin tick(); n++; end
        sif.din_valid = 1'b0;
        repeat (3) tick();
        chk_cnt++; if (word_cnt !== 8'h00) $display("FAIL wrap_zero: got %h want 00", word_cnt); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (ks_level != 3'd4 && n < 60) begin tick(); n++; end
        repeat (8) tick();
        sif.din_valid = 1'b1;
        tick();
        sif.din_valid = 1'b0;
        n = 0;
        while (pend == 0 && n < 10) begin tick(); n++; end
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (ks_next !== 1'b0) $display("FAIL arst_ks_next: got %b want 0", ks_next); else pass_cnt++;
        chk_cnt++; if (sif.din_ready !== 1'b0) $display("FAIL arst_din_ready: got %b want 0", sif.din_ready); else pass_cnt++;
        chk_cnt++; if (sif.dout !== 32'h0) $display("FAIL arst_dout: got %h want 0", sif.dout); else pass_cnt++;
        chk_cnt++; if (sif.dout_valid !== 1'b0) $display("FAIL arst_dout_valid: got %b want 0", sif.dout_valid); else pass_cnt++;
        chk_cnt++; if (ks_level !== 3'd0) $display("FAIL arst_level: got %0d want 0", ks_level); else pass_cnt++;
        chk_cnt++; if (word_cnt !== 8'd0) $display("FAIL arst_word_cnt: got %0d want 0", word_cnt); else pass_cnt++;
        exp_ks.delete(); data_sb.delete();
        repeat (4) tick();
        reset_n = 1'b1;
        tick();
        chk_cnt++; if (word_cnt !== 8'd0) $display("FAIL arst_release_cnt: got %0d want 0", word_cnt); else pass_cnt++;
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_xor();
        test_backpressure();
        test_empty();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
